baby_vga_fb_store: RTL and testbench

//  Bit-mapped frame store for the baby VGA peripheral: 16 rows x 32 pixels, 1 bpp.
//  - CPU side: 32-bit write port and a request/ready 32-bit read port.
//  - Display side: a tear-free line buffer, reloaded once per display row, drives the pixel mux.
//  - Sequential clear engine zeroes the array after reset and on command.

---
 rtl/baby_vga_fb_store.sv | 134 +++++++++++++
 tb/tb_baby_vga_fb_store.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baby_vga_fb_store.sv
`default_nettype none
// ============================================================================
//  Module      : baby_vga_fb_store
//  Description : 16x32 1-bpp frame store with a CPU write/read port, a
//                tear-free display line buffer and a sequential clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module baby_vga_fb_store #(
    parameter int ROWS   = 16,
    parameter int COLS   = 32,
    parameter int RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(ROWS)-1:0]  wr_addr,
    input  logic [COLS-1:0]          wr_data,
    input  logic                     rd_req,
    input  logic [$clog2(ROWS)-1:0]  rd_addr,
    output logic [COLS-1:0]          rd_data,
    output logic                     rd_ready,
    input  logic                     line_load,
    input  logic [$clog2(ROWS)-1:0]  line_addr,
    output logic [COLS-1:0]          line_data,
    input  logic                     clear,
    output logic                     clear_busy
);

    localparam int c_AW = $clog2(ROWS);
    localparam int c_CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_CLEARING = 1'b1;

    localparam logic [c_AW-1:0] c_LAST_ROW = c_AW'(ROWS - 1);
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(RD_LAT - 1);

    logic [0:0]      r_state;
    logic [c_AW-1:0] r_ptr;
    logic [COLS-1:0] r_mem [ROWS];

    logic            r_pending;
    logic [c_CW-1:0] r_cnt;
    logic [COLS-1:0] r_capt;
    logic [COLS-1:0] r_rd_data;
    logic            r_rd_ready;
    logic [COLS-1:0] r_line_data;

    logic            w_clearing;
    logic            w_we;
    logic [c_AW-1:0] w_waddr;
    logic [COLS-1:0] w_wdata;
    logic            w_accept;
    logic [COLS-1:0] w_rd_row;
    logic [COLS-1:0] w_line_row;

    // Clear engine: one row per cycle, exactly ROWS busy cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEARING;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (clear) begin
                        r_state <= c_ST_CLEARING;
                        r_ptr   <= '0;
                    end
                end
                c_ST_CLEARING: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == c_LAST_ROW) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Single effective write port: the clear engine owns it while busy
    always_comb begin
        w_clearing = (r_state == c_ST_CLEARING);
        w_we       = !rst && (w_clearing || wr_en);
        w_waddr    = w_clearing ? r_ptr : wr_addr;
        w_wdata    = w_clearing ? '0 : wr_data;
        w_accept   = rd_req && (r_state == c_ST_IDLE) && !r_pending;
        w_rd_row   = (w_we && (w_waddr == rd_addr))   ? w_wdata : r_mem[rd_addr];
        w_line_row = (w_we && (w_waddr == line_addr)) ? w_wdata : r_mem[line_addr];
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read pipeline: capture at accept, present RD_LAT cycles later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 1'b0;
            r_cnt       <= '0;
            r_capt      <= '0;
            r_rd_data   <= '0;
            r_rd_ready  <= 1'b0;
            r_line_data <= '0;
        end else begin
            r_rd_ready <= 1'b0;
            if (w_accept) begin
                r_pending <= 1'b1;
                r_cnt     <= c_CNT_INIT;
                r_capt    <= w_rd_row;
            end else if (r_pending) begin
                if (r_cnt == '0) begin
                    r_pending  <= 1'b0;
                    r_rd_ready <= 1'b1;
                    r_rd_data  <= r_capt;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            if (line_load) begin
                r_line_data <= w_line_row;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_ready   = r_rd_ready;
    assign line_data  = r_line_data;
    assign clear_busy = w_clearing;

endmodule
`default_nettype wire

// File: tb/tb_baby_vga_fb_store.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baby_vga_fb_store
//  Description : Scoreboard bench for baby_vga_fb_store with a row-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_baby_vga_fb_store;

    localparam int c_ROWS   = 16;
    localparam int c_COLS   = 32;
    localparam int c_RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_req = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic        line_load = 1'b0;
    logic [3:0]  line_addr = '0;
    logic [31:0] line_data;
    logic        clear = 1'b0;
    logic        clear_busy;

    baby_vga_fb_store #(.ROWS(c_ROWS), .COLS(c_COLS), .RD_LAT(c_RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .line_load(line_load), .line_addr(line_addr), .line_data(line_data),
        .clear(clear), .clear_busy(clear_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         exp_q[$];
    logic [31:0] m_mem [c_ROWS];
    int          m_cyc       = 0;
    int          m_clr_left  = 0;
    int          m_clr_row   = 0;
    int          m_busy_till = -1;
    int          m_rst_cyc   = -1;
    logic [31:0] m_line      = '0;

    always @(posedge clk) begin
        logic        busy, we;
        int          wa;
        logic [31:0] wd;
        m_cyc++;
        if (rst) begin
            m_clr_left  = c_ROWS;
            m_clr_row   = 0;
            m_line      = '0;
            m_busy_till = m_cyc;
            m_rst_cyc   = m_cyc;
        end else begin
            busy = (m_clr_left > 0);
            we   = busy ? 1'b1 : wr_en;
            wa   = busy ? m_clr_row : int'(wr_addr);
            wd   = busy ? 32'h0 : wr_data;
            if (rd_req && !busy && m_cyc > m_busy_till) begin
                rd_t e;
                e.data = (we && wa == int'(rd_addr)) ? wd : m_mem[rd_addr];
                e.due  = m_cyc + c_RD_LAT;
                exp_q.push_back(e);
                m_busy_till = e.due;
            end
            if (line_load)
                m_line = (we && wa == int'(line_addr)) ? wd : m_mem[line_addr];
            if (we) m_mem[wa] = wd;
            if (busy) begin
                m_clr_row++;
                m_clr_left--;
            end else if (clear) begin
                m_clr_left = c_ROWS;
                m_clr_row  = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        mon_en = 1'b0;
    logic [31:0] held   = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_rst_cyc == m_cyc) begin
                exp_q.delete();
                held = '0;
            end
            if (rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rd_ready_unexpected", 32'd1, 32'd0);
                end else begin
                    rd_t e;
                    e = exp_q.pop_front();
                    chk("rd_ready_timing", 32'(m_cyc), 32'(e.due));
                    held = e.data;
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= m_cyc) begin
                chk("rd_ready_missing", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            chk("rd_data", rd_data, held);
            chk("line_data", line_data, m_line);
            chk("clear_busy", 32'(clear_busy), 32'(m_clr_left > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!rd_ready && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(rd_ready), 32'd1);
        rd_req = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        wait_ready("rd_timeout");
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int cnt = 0;
        while (clear_busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk(name, 32'(cnt), 32'd16);
    endtask

    initial begin
        tick();
        tick();
        mon_en = 1'b1;
        rst = 1'b0;
        count_busy("busy_after_rst");
        for (int r = 0; r < c_ROWS; r++) do_read(4'(r));

        do_write(4'd3, 32'hDEADBEEF);
        do_read(4'd3);

        // same-cycle write and read of one row
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h12345678;
        rd_req = 1'b1; rd_addr = 4'd5;
        tick();
        wr_en = 1'b0;
        wait_ready("rd_bypass_timeout");

        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5A5A5A5;
        line_load = 1'b1; line_addr = 4'd7;
        tick();
        wr_en = 1'b0; line_load = 1'b0;
        chk("line_bypass", line_data, 32'hA5A5A5A5);

        do_write(4'd2, 32'h0000FFFF);
        line_load = 1'b1; line_addr = 4'd2;
        tick();
        line_load = 1'b0;
        do_write(4'd2, 32'hFFFF0000);
        tick();
        chk("line_no_tear", line_data, 32'h0000FFFF);
        line_load = 1'b1;
        tick();
        line_load = 1'b0;
        chk("line_reload", line_data, 32'hFFFF0000);

        do_write(4'd9, 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rd_req = 1'b1; rd_addr = 4'd9;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 1'b0;
        wait_ready("rd_held_timeout");
        chk("rd_after_clear", rd_data, 32'h0);
        do_read(4'd1);

        line_load = 1'b1; line_addr = 4'd3;
        tick();
        line_load = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        rd_req = 1'b1; rd_addr = 4'd3;
        tick();
        rst = 1'b0;
        chk("rst_line", line_data, 32'h0);
        count_busy("busy_after_rst_restart");
        rd_req = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = 4'($urandom);
            wr_data   = $urandom;
            rd_req    = ($urandom_range(0, 3) == 0);
            rd_addr   = 4'($urandom);
            line_load = ($urandom_range(0, 3) == 0);
            line_addr = 4'($urandom);
            clear     = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; wr_en = 1'b0; rd_req = 1'b0; line_load = 1'b0; clear = 1'b0;
        repeat (40) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
